// File: rtl/siso_ctrl_pkg.sv
// rtl/siso_ctrl_pkg.sv - shared state encoding and default sizes for the serial arbiter
package siso_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/siso_delay.sv
// rtl/siso_delay.sv - DEPTH-stage serial delay line, output is the input DEPTH cycles earlier
module siso_delay #(
    parameter int DEPTH = siso_ctrl_pkg::DEF_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic srl_in,
    output logic srl_out
);

    logic [DEPTH-1:0] stage_q;
    logic [DEPTH-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[DEPTH-2:0], srl_in};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign srl_out = stage_q[DEPTH-1];

endmodule

// File: rtl/siso_arb_ctrl.sv
// rtl/siso_arb_ctrl.sv - round-robin two-requester arbiter sending each word through a serial delay line
module siso_arb_ctrl
    import siso_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_id,
    output logic             mismatch
);

    localparam int CW = $clog2(WIDTH + DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH + DEPTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             id_q, id_d;
    logic             rx_id_q, rx_id_d;
    logic             last_q, last_d;
    logic             pick1;
    logic             srl_in;
    logic             srl_out;

    siso_delay #(.DEPTH(DEPTH)) u_delay (
        .clk     (clk),
        .rst     (rst),
        .srl_in  (srl_in),
        .srl_out (srl_out)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        word_d    = word_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        id_d      = id_q;
        rx_id_d   = rx_id_q;
        last_d    = last_q;
        pick1     = 1'b0;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        srl_in    = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the requester that was not granted last wins
                if (rst && (req0 || req1)) begin
                    pick1   = req1 && (!req0 || !last_q);
                    gnt0    = !pick1;
                    gnt1    = pick1;
                    tx_d    = pick1 ? data1 : data0;
                    word_d  = pick1 ? data1 : data0;
                    id_d    = pick1;
                    last_d  = pick1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q < CW'(WIDTH)) begin
                    srl_in = tx_q[WIDTH-1];
                    tx_d   = tx_q << 1;
                end
                if (cnt_q >= CW'(DEPTH)) begin
                    rx_d = {rx_q[WIDTH-2:0], srl_out};
                end
                cnt_d = cnt_q + CW'(1);
                // Publish the completed word so it is already visible during DONE
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    rx_data_d = rx_d;
                    rx_id_d   = id_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tx_q      <= '0;
            word_q    <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            id_q      <= 1'b0;
            rx_id_q   <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            word_q    <= word_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            id_q      <= id_d;
            rx_id_q   <= rx_id_d;
            last_q    <= last_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign rx_data  = rx_data_q;
    assign rx_id    = rx_id_q;
    assign mismatch = done && (rx_data_q != word_q);

endmodule

// File: tb/tb_siso_arb_ctrl.sv
// tb/tb_siso_arb_ctrl.sv - directed self-checking bench for siso_arb_ctrl
module tb_siso_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0;
    logic [3:0] data0 = 4'h0;
    logic       req1 = 1'b0;
    logic [3:0] data1 = 4'h0;
    logic       gnt0, gnt1, busy, done, rx_id, mismatch;
    logic [3:0] rx_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    siso_arb_ctrl #(.WIDTH(4), .DEPTH(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .data0    (data0),
        .req1     (req1),
        .data1    (data1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .rx_id    (rx_id),
        .mismatch (mismatch)
    );

    // Inputs change 1 ns after the rising edge, outputs are sampled 1 ns later
    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_gnt(input int bound, output int n, output logic g0, output logic g1);
        n = 0;
        g0 = 1'b0;
        g1 = 1'b0;
        while (!(gnt0 || gnt1)) begin
            if (n >= bound) begin
                n = -1;
                return;
            end
            tick();
            #1;
            n++;
        end
        g0 = gnt0;
        g1 = gnt1;
    endtask

    task automatic wait_done(input int bound, output logic found);
        int n;
        n = 0;
        found = 1'b0;
        while (!found && n < bound) begin
            tick();
            #1;
            n++;
            found = done;
        end
    endtask

    task automatic apply_reset;
        tick();
        rst = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        tick();
        rst = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        #1;
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt_suppressed: gnt0=%b gnt1=%b expected 0 0", gnt0, gnt1);
        end
        tick();
        #1;
        checks++;
        if ({gnt0, gnt1, busy, done, mismatch, rx_id, rx_data} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: gnt0=%b gnt1=%b busy=%b done=%b mismatch=%b rx_id=%b rx_data=%h expected all 0",
                     gnt0, gnt1, busy, done, mismatch, rx_id, rx_data);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_single;
        int n, gcyc;
        logic g0, g1, found;
        tick();
        req0 = 1'b1;
        data0 = 4'b1011;
        #1;
        wait_gnt(5, n, g0, g1);
        gcyc = cyc;
        checks++;
        if (n !== 0 || g0 !== 1'b1 || g1 !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt: wait=%0d gnt0=%b gnt1=%b expected 0 1 0", n, g0, g1);
        end
        tick();
        req0 = 1'b0;
        #1;
        checks++;
        if (gnt0 !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gnt_pulse: gnt0=%b busy=%b expected 0 1", gnt0, busy);
        end
        wait_done(30, found);
        checks++;
        if (!found || cyc - gcyc != 9) begin
            errors++;
            $display("FAIL single_latency: found=%b latency=%0d expected 1 9", found, cyc - gcyc);
        end
        checks++;
        if (rx_data !== 4'b1011 || rx_id !== 1'b0 || mismatch !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_result: rx_data=%h rx_id=%b mismatch=%b busy=%b expected b 0 0 1",
                     rx_data, rx_id, mismatch, busy);
        end
        tick();
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rx_data !== 4'b1011 || rx_id !== 1'b0) begin
            errors++;
            $display("FAIL single_hold: busy=%b done=%b rx_data=%h rx_id=%b expected 0 0 b 0",
                     busy, done, rx_data, rx_id);
        end
    endtask

    task automatic test_round_robin;
        int n, prev;
        logic g0, g1, found;
        logic [3:0] exp_d;
        apply_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        data0 = 4'h3;
        data1 = 4'hC;
        #1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(30, n, g0, g1);
            checks++;
            if (n < 0 || g0 !== (k % 2 == 0) || g1 !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL rr_order[%0d]: wait=%0d gnt0=%b gnt1=%b expected gnt1=%0d", k, n, g0, g1, k % 2);
            end
            if (k > 0) begin
                checks++;
                if (n !== 1) begin
                    errors++;
                    $display("FAIL rr_regrant[%0d]: wait=%0d expected 1", k, n);
                end
            end
            wait_done(30, found);
            exp_d = (k % 2 == 0) ? 4'h3 : 4'hC;
            checks++;
            if (!found || rx_data !== exp_d || rx_id !== 1'(k % 2) || mismatch !== 1'b0) begin
                errors++;
                $display("FAIL rr_result[%0d]: found=%b rx_data=%h rx_id=%b mismatch=%b expected %h %0d 0",
                         k, found, rx_data, rx_id, mismatch, exp_d, k % 2);
            end
            if (k > 0) begin
                checks++;
                if (cyc - prev != 10) begin
                    errors++;
                    $display("FAIL rr_spacing[%0d]: done spacing=%0d expected 10", k, cyc - prev);
                end
            end
            prev = cyc;
        end
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        #1;
    endtask

    task automatic test_req_during_run;
        int n;
        logic g0, g1, found, early;
        tick();
        req0 = 1'b1;
        data0 = 4'h5;
        #1;
        wait_gnt(5, n, g0, g1);
        checks++;
        if (n !== 0 || g0 !== 1'b1) begin
            errors++;
            $display("FAIL run_first_gnt: wait=%0d gnt0=%b expected 0 1", n, g0);
        end
        tick();
        req0 = 1'b0;
        req1 = 1'b1;
        data1 = 4'hA;
        #1;
        early = gnt1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            #1;
            early = early | gnt1;
            found = done;
        end
        checks++;
        if (early !== 1'b0 || !found) begin
            errors++;
            $display("FAIL run_ignore_req1: gnt1_seen=%b done_seen=%b expected 0 1", early, found);
        end
        tick();
        #1;
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL run_gnt1_after_done: gnt1=%b gnt0=%b expected 1 0", gnt1, gnt0);
        end
        tick();
        req1 = 1'b0;
        #1;
        wait_done(30, found);
        checks++;
        if (!found || rx_data !== 4'hA || rx_id !== 1'b1) begin
            errors++;
            $display("FAIL run_second_result: found=%b rx_data=%h rx_id=%b expected 1 a 1", found, rx_data, rx_id);
        end
    endtask

    task automatic test_reset_mid_run;
        int n, gcyc;
        logic g0, g1, found, seen;
        tick();
        req0 = 1'b1;
        data0 = 4'hF;
        #1;
        wait_gnt(5, n, g0, g1);
        tick();
        req0 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        tick();
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || u_dut.u_delay.srl_out !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b srl_out=%b expected 0 0 0",
                     busy, done, u_dut.u_delay.srl_out);
        end
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            #1;
            seen = seen | done;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_done: done_seen=%b expected 0", seen);
        end
        req0 = 1'b1;
        data0 = 4'h6;
        #1;
        wait_gnt(5, n, g0, g1);
        gcyc = cyc;
        tick();
        req0 = 1'b0;
        #1;
        wait_done(30, found);
        checks++;
        if (!found || cyc - gcyc != 9 || rx_data !== 4'h6 || mismatch !== 1'b0) begin
            errors++;
            $display("FAIL midrun_recover: found=%b latency=%0d rx_data=%h mismatch=%b expected 1 9 6 0",
                     found, cyc - gcyc, rx_data, mismatch);
        end
    endtask

    task automatic test_fault;
        int n;
        logic g0, g1, found;
        tick();
        req0 = 1'b1;
        data0 = 4'h9;
        #1;
        wait_gnt(5, n, g0, g1);
        tick();
        req0 = 1'b0;
        tick();
        tick();
        tick();
        tick();
        force u_dut.u_delay.stage_q = 4'b0000;
        tick();
        release u_dut.u_delay.stage_q;
        #1;
        wait_done(30, found);
        checks++;
        if (!found || mismatch !== 1'b1 || rx_data === 4'h9) begin
            errors++;
            $display("FAIL fault_detect: found=%b mismatch=%b rx_data=%h expected 1 1 not-9", found, mismatch, rx_data);
        end
    endtask

    task automatic test_all_values;
        int n, bad;
        logic g0, g1, found;
        bad = 0;
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < 16; v++) begin
                tick();
                if (r == 0) begin
                    req0 = 1'b1;
                    data0 = 4'(v);
                end else begin
                    req1 = 1'b1;
                    data1 = 4'(v);
                end
                #1;
                wait_gnt(5, n, g0, g1);
                tick();
                req0 = 1'b0;
                req1 = 1'b0;
                #1;
                wait_done(30, found);
                checks++;
                if (n < 0 || g1 !== 1'(r) || !found || rx_data !== 4'(v) || rx_id !== 1'(r) || mismatch !== 1'b0) begin
                    errors++;
                    $display("FAIL all_values[r%0d v%0d]: gnt1=%b found=%b rx_data=%h rx_id=%b mismatch=%b expected %0d 1 %h %0d 0",
                             r, v, g1, found, rx_data, rx_id, mismatch, r, v, r);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_req_during_run();
        test_reset_mid_run();
        test_fault();
        test_all_values();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/siso_arb_ctrl.md
SISO_ARB_CTRL -- requirements
Module: siso_arb_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WIDTH, 4: data word width in bits.
- DEPTH, 4: number of stages in the serial delay line.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, input, 1: single clock; all state changes on its rising edge.
- rst, input, 1: reset; synchronous, active-low (rst=0 resets on the next rising clk edge).
- req0, input, 1: requester 0 wants a transfer.
- data0, input, WIDTH: requester 0 word.
- req1, input, 1: requester 1 wants a transfer.
- data1, input, WIDTH: requester 1 word.
- gnt0, output, 1: one-cycle grant to requester 0; data0 sampled this cycle.
- gnt1, output, 1: one-cycle grant to requester 1; data1 sampled this cycle.
- busy, output, 1: transfer in progress.
- done, output, 1: one-cycle pulse; rx_data, rx_id and mismatch valid.
- rx_data, output, WIDTH: word recovered from the serial delay line.
- rx_id, output, 1: requester index of the completed transfer.
- mismatch, output, 1: rx_data differs from the sent word; valid with done.

Function
REQ-003 FSM states SHALL be IDLE, RUN and DONE, with a counter cnt of width clog2(WIDTH+DEPTH).
REQ-004 In IDLE with req0|req1 high, gnt0/gnt1 SHALL assert combinationally for that cycle; the granted word is latched into tx_reg, the index into id_reg, cnt is set to 0, and the FSM enters RUN.
REQ-005 Arbitration SHALL be round-robin: if both requests are high, grant the requester not granted last; a single request is always granted; after reset, req0 wins the first tie.
REQ-006 Grants SHALL occur only in IDLE; requests in RUN/DONE are ignored, and requesters hold req until granted.
REQ-007 In RUN, the delay-line input SHALL be:
- tx_reg MSB (MSB-first, tx_reg shifting left) while cnt<WIDTH;
- 0 while cnt>=WIDTH.
REQ-008 The delay line SHALL present at its output, in any cycle, the bit input DEPTH cycles earlier.
REQ-009 In RUN with cnt>=DEPTH, the controller SHALL shift the delay-line output into the rx shift register at the LSB (shift left).
REQ-010 RUN SHALL last exactly WIDTH+DEPTH cycles (cnt 0..WIDTH+DEPTH-1), then enter DONE.
REQ-011 DONE SHALL last one cycle with:
- done=1;
- rx_data = received word;
- rx_id = id_reg;
- mismatch = (rx_data != original word).
The FSM SHALL then return to IDLE.
REQ-012 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-013 Latency from the grant cycle to done SHALL be WIDTH+DEPTH+1 cycles (9 for the defaults). The next grant is possible in the cycle after done, so back-to-back transfers take WIDTH+DEPTH+2 cycles each.
REQ-014 rx_data and rx_id SHALL hold their values after done until the next DONE.

Reset
REQ-015 With rst=0 at a clock edge, the block SHALL, from any state including mid-RUN:
- enter IDLE;
- clear cnt, tx_reg, rx register, id_reg and all delay-line stages;
- set last-grant to 1.
REQ-016 Output reset values SHALL be gnt0=gnt1=busy=done=mismatch=0, rx_data=0 and rx_id=0; gnt is suppressed while rst=0.
REQ-017 A transfer aborted by reset SHALL produce no done pulse.

Structure
REQ-018 A shared package siso_ctrl_pkg SHALL hold the state encoding constants (IDLE, RUN, DONE) and the default WIDTH/DEPTH values.
REQ-019 The delay line SHALL be a sub-module siso_delay (parameter DEPTH; ports clk, rst, srl_in, srl_out; synchronous active-low reset), instantiated once.

Verification
REQ-020 Reset, then req0=1 with data0=4'b1011, held until gnt0 -> gnt0 pulses for one cycle; done exactly 9 cycles later with rx_data=1011, rx_id=0, mismatch=0.
REQ-021 req0 and req1 held high, data0=4'h3, data1=4'hC, for 4 transfers -> grant order 0,1,0,1; rx pairs (3,0),(C,1) repeated; each done 10 cycles after the previous one.
REQ-022 req1 asserted during RUN of a req0 transfer -> no gnt1 until the cycle after done; then gnt1 is issued.
REQ-023 rst=0 applied at RUN cycle cnt=3 -> next cycle busy=0, no done, and siso_delay output is 0; a new req0 with data0=4'h6 completes with rx_data=6.
REQ-024 Force a siso_delay stage to the wrong value during transfer of 4'h9 -> at done, mismatch=1 and rx_data≠9.
REQ-025 All data values 0..15 from each requester -> rx_data matches the sent word in every case and mismatch stays 0.
